// File: rtl/data_org_pkg.sv
// Shared sizing defaults and helpers for the sample bank.
package data_org_pkg;

    localparam int unsigned DEF_DATA_W   = 11;
    localparam int unsigned DEF_CHANNELS = 64;
    localparam int unsigned FRAME_CNT_W  = 16;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_bank_decoder.sv
// Write address decoder: one-hot channel enable plus out-of-range flag.
module sample_bank_decoder
    import data_org_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned ADDR_W   = clog2(CHANNELS)
) (
    input  logic                valid_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [CHANNELS-1:0] wr_en_c_o,
    output logic                range_err_c_o
);

    // Decode the address against every channel and flag writes past the end.
    always_comb begin
        wr_en_c_o     = '0;
        range_err_c_o = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            wr_en_c_o[k] = valid_i && (32'(addr_i) == k);
        end
        range_err_c_o = valid_i && (32'(addr_i) >= CHANNELS);
    end

endmodule

// File: rtl/sample_bank_db.sv
// Double-buffered sample bank: writes land in a shadow bank, and a commit
// copies the whole shadow bank (including a same-cycle write) to the active
// bank that drives the parallel output.
module sample_bank_db
    import data_org_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CHANNELS    = DEF_CHANNELS,
    parameter int unsigned AUTO_COMMIT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [clog2(CHANNELS)-1:0]    wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          frame_end,
    output logic [CHANNELS*DATA_W-1:0]    signals,
    output logic                          frame_valid,
    output logic [CHANNELS-1:0]           fill_mask,
    output logic                          addr_err,
    output logic [FRAME_CNT_W-1:0]        frame_cnt
);

    localparam int unsigned ADDR_W = clog2(CHANNELS);

    logic [DATA_W-1:0]      shadow_q [CHANNELS];
    logic [DATA_W-1:0]      shadow_d [CHANNELS];
    logic [DATA_W-1:0]      active_q [CHANNELS];
    logic [DATA_W-1:0]      active_d [CHANNELS];
    logic [CHANNELS-1:0]    fill_q;
    logic [CHANNELS-1:0]    fill_d;
    logic                   frame_valid_q;
    logic                   frame_valid_d;
    logic                   addr_err_q;
    logic                   addr_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;

    logic [CHANNELS-1:0]    wr_en_c;
    logic                   range_err_c;
    logic [CHANNELS-1:0]    filled_c;
    logic                   commit_c;

    sample_bank_decoder #(
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W)
    ) u_decoder (
        .valid_i       (wr_valid),
        .addr_i        (wr_addr),
        .wr_en_c_o     (wr_en_c),
        .range_err_c_o (range_err_c)
    );

    // Next-state: shadow update, commit detection and bank transfer.
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        filled_c      = fill_q | wr_en_c;
        fill_d        = filled_c;
        frame_cnt_d   = frame_cnt_q;
        commit_c      = frame_end || ((AUTO_COMMIT != 0) && (&filled_c));
        frame_valid_d = commit_c;
        addr_err_d    = range_err_c;

        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (wr_en_c[k]) begin
                shadow_d[k] = wr_data;
            end
        end

        // Commit sees the shadow bank with this cycle's write already merged.
        if (commit_c) begin
            active_d    = shadow_d;
            fill_d      = '0;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    // State registers with asynchronous clear of both banks and all flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            fill_q        <= '0;
            frame_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            fill_q        <= fill_d;
            frame_valid_q <= frame_valid_d;
            addr_err_q    <= addr_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Flatten the active bank onto the parallel output bus.
    always_comb begin
        signals = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            signals[k*DATA_W +: DATA_W] = active_q[k];
        end
    end

    assign frame_valid = frame_valid_q;
    assign fill_mask   = fill_q;
    assign addr_err    = addr_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sample_bank_db.sv
// Bench for sample_bank_db: instance A auto-commits with 64 channels,
// instance B commits on frame_end only with 48 channels.
module tb_sample_bank_db;

    logic clk;
    logic rst_n;

    logic         a_wv;
    logic [5:0]   a_wa;
    logic [10:0]  a_wd;
    logic         a_fe;
    logic [703:0] a_sig;
    logic         a_fv;
    logic [63:0]  a_fm;
    logic         a_err;
    logic [15:0]  a_cnt;

    logic         b_wv;
    logic [5:0]   b_wa;
    logic [10:0]  b_wd;
    logic         b_fe;
    logic [527:0] b_sig;
    logic         b_fv;
    logic [47:0]  b_fm;
    logic         b_err;
    logic [15:0]  b_cnt;

    int n_cmp;
    int n_bad;

    // Reference model state, index 0 = A, 1 = B
    logic [10:0] m_shadow [2][64];
    logic [10:0] m_active [2][64];
    logic [63:0] m_fill   [2];
    logic [15:0] m_cnt    [2];
    logic        m_fv     [2];
    logic        m_err    [2];

    sample_bank_db #(.DATA_W(11), .CHANNELS(64), .AUTO_COMMIT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_valid(a_wv), .wr_addr(a_wa), .wr_data(a_wd),
        .frame_end(a_fe), .signals(a_sig), .frame_valid(a_fv), .fill_mask(a_fm),
        .addr_err(a_err), .frame_cnt(a_cnt)
    );

    sample_bank_db #(.DATA_W(11), .CHANNELS(48), .AUTO_COMMIT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_valid(b_wv), .wr_addr(b_wa), .wr_data(b_wd),
        .frame_end(b_fe), .signals(b_sig), .frame_valid(b_fv), .fill_mask(b_fm),
        .addr_err(b_err), .frame_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 64; k++) begin
                m_shadow[d][k] = '0;
                m_active[d][k] = '0;
            end
            m_fill[d] = '0;
            m_cnt[d]  = '0;
            m_fv[d]   = 1'b0;
            m_err[d]  = 1'b0;
        end
    endtask

    // One clock edge of the frame-buffer behaviour for one instance.
    task automatic model_edge(input int d, input logic v, input logic [5:0] a,
                              input logic [10:0] dat, input logic fe);
        int chans;
        bit all_full;
        chans    = (d == 0) ? 64 : 48;
        m_err[d] = 1'b0;
        if (v) begin
            if (int'(a) < chans) begin
                m_shadow[d][a] = dat;
                m_fill[d][a]   = 1'b1;
            end else begin
                m_err[d] = 1'b1;
            end
        end
        all_full = 1'b1;
        for (int k = 0; k < chans; k++) if (!m_fill[d][k]) all_full = 1'b0;
        if (fe || (d == 0 && all_full)) begin
            for (int k = 0; k < 64; k++) m_active[d][k] = m_shadow[d][k];
            m_fill[d] = '0;
            m_cnt[d]  = m_cnt[d] + 16'd1;
            m_fv[d]   = 1'b1;
        end else begin
            m_fv[d] = 1'b0;
        end
    endtask

    function automatic logic [703:0] exp_a_sig();
        logic [703:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) r[k*11 +: 11] = m_active[0][k];
        return r;
    endfunction

    function automatic logic [527:0] exp_b_sig();
        logic [527:0] r;
        r = '0;
        for (int k = 0; k < 48; k++) r[k*11 +: 11] = m_active[1][k];
        return r;
    endfunction

    task automatic idle();
        a_wv = 1'b0; a_fe = 1'b0; a_wa = '0; a_wd = '0;
        b_wv = 1'b0; b_fe = 1'b0; b_wa = '0; b_wd = '0;
    endtask

    // Advance one clock, update the model with the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        model_edge(0, a_wv, a_wa, a_wd, a_fe);
        model_edge(1, b_wv, b_wa, b_wd, b_fe);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++; if (a_sig !== 704'd0) begin n_bad++; $display("FAIL reset_a_sig: got %h want 0", a_sig); end
        n_cmp++; if (a_fv !== 1'b0)    begin n_bad++; $display("FAIL reset_a_fv: got %b want 0", a_fv); end
        n_cmp++; if (a_fm !== 64'd0)   begin n_bad++; $display("FAIL reset_a_fm: got %h want 0", a_fm); end
        n_cmp++; if (a_err !== 1'b0)   begin n_bad++; $display("FAIL reset_a_err: got %b want 0", a_err); end
        n_cmp++; if (a_cnt !== 16'd0)  begin n_bad++; $display("FAIL reset_a_cnt: got %h want 0", a_cnt); end
        n_cmp++; if (b_sig !== 528'd0) begin n_bad++; $display("FAIL reset_b_sig: got %h want 0", b_sig); end
        n_cmp++; if (b_fm !== 48'd0)   begin n_bad++; $display("FAIL reset_b_fm: got %h want 0", b_fm); end
        n_cmp++; if (b_cnt !== 16'd0)  begin n_bad++; $display("FAIL reset_b_cnt: got %h want 0", b_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_auto_fill();
        logic [703:0] e;
        for (int k = 0; k < 64; k++) begin
            a_wv = 1'b1; a_wa = 6'(k); a_wd = 11'(k + 100);
            tick();
            if (k < 63) begin
                n_cmp++; if (a_fv !== 1'b0) begin n_bad++; $display("FAIL auto_early_fv: ch %0d got %b want 0", k, a_fv); end
                n_cmp++; if (a_fm !== m_fill[0]) begin n_bad++; $display("FAIL auto_fill_mask: ch %0d got %h want %h", k, a_fm, m_fill[0]); end
            end
        end
        idle();
        e = '0;
        for (int k = 0; k < 64; k++) e[k*11 +: 11] = 11'(k + 100);
        n_cmp++; if (a_sig !== e)     begin n_bad++; $display("FAIL auto_sig: got %h want %h", a_sig, e); end
        n_cmp++; if (a_fv !== 1'b1)   begin n_bad++; $display("FAIL auto_fv: got %b want 1", a_fv); end
        n_cmp++; if (a_cnt !== 16'd1) begin n_bad++; $display("FAIL auto_cnt: got %h want 1", a_cnt); end
        n_cmp++; if (a_fm !== 64'd0)  begin n_bad++; $display("FAIL auto_fm_clear: got %h want 0", a_fm); end
        tick();
        n_cmp++; if (a_fv !== 1'b0)   begin n_bad++; $display("FAIL auto_fv_drop: got %b want 0", a_fv); end
        n_cmp++; if (a_sig !== e)     begin n_bad++; $display("FAIL auto_sig_hold: got %h want %h", a_sig, e); end
    endtask

    task automatic test_rewrite();
        logic [527:0] e;
        b_wv = 1'b1; b_wa = 6'd5; b_wd = 11'h3FF;
        tick();
        b_wa = 6'd5; b_wd = 11'h001;
        tick();
        idle();
        n_cmp++; if (b_sig !== 528'd0) begin n_bad++; $display("FAIL rewrite_no_commit: got %h want 0", b_sig); end
        b_fe = 1'b1;
        tick();
        idle();
        e = '0;
        e[5*11 +: 11] = 11'h001;
        n_cmp++; if (b_sig !== e)     begin n_bad++; $display("FAIL rewrite_sig: got %h want %h", b_sig, e); end
        n_cmp++; if (b_cnt !== 16'd1) begin n_bad++; $display("FAIL rewrite_cnt: got %h want 1", b_cnt); end
        n_cmp++; if (b_fv !== 1'b1)   begin n_bad++; $display("FAIL rewrite_fv: got %b want 1", b_fv); end
        n_cmp++; if (b_fm !== 48'd0)  begin n_bad++; $display("FAIL rewrite_fm: got %h want 0", b_fm); end
    endtask

    task automatic test_addr_err();
        logic [527:0] e;
        e = '0;
        e[5*11 +: 11] = 11'h001;
        b_wv = 1'b1; b_wa = 6'd3; b_wd = 11'h012;
        tick();
        b_wa = 6'd50; b_wd = 11'h7FF;
        tick();
        idle();
        n_cmp++; if (b_err !== 1'b1)  begin n_bad++; $display("FAIL addr_err_pulse: got %b want 1", b_err); end
        n_cmp++; if (b_fm !== 48'h8)  begin n_bad++; $display("FAIL addr_err_fm: got %h want 8", b_fm); end
        n_cmp++; if (b_fv !== 1'b0)   begin n_bad++; $display("FAIL addr_err_fv: got %b want 0", b_fv); end
        n_cmp++; if (b_sig !== e)     begin n_bad++; $display("FAIL addr_err_sig: got %h want %h", b_sig, e); end
        tick();
        n_cmp++; if (b_err !== 1'b0)  begin n_bad++; $display("FAIL addr_err_drop: got %b want 0", b_err); end
        n_cmp++; if (b_cnt !== 16'd1) begin n_bad++; $display("FAIL addr_err_cnt: got %h want 1", b_cnt); end
    endtask

    task automatic test_same_cycle();
        logic [527:0] e;
        b_wv = 1'b1; b_wa = 6'd2; b_wd = 11'd7; b_fe = 1'b1;
        tick();
        idle();
        e = '0;
        e[5*11 +: 11] = 11'h001;
        e[3*11 +: 11] = 11'h012;
        e[2*11 +: 11] = 11'd7;
        n_cmp++; if (b_sig !== e)     begin n_bad++; $display("FAIL same_cycle_sig: got %h want %h", b_sig, e); end
        n_cmp++; if (b_fm !== 48'd0)  begin n_bad++; $display("FAIL same_cycle_fm: got %h want 0", b_fm); end
        n_cmp++; if (b_cnt !== 16'd2) begin n_bad++; $display("FAIL same_cycle_cnt: got %h want 2", b_cnt); end
        n_cmp++; if (b_fv !== 1'b1)   begin n_bad++; $display("FAIL same_cycle_fv: got %b want 1", b_fv); end
    endtask

    task automatic test_back_to_back();
        b_fe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (b_fv !== 1'b1) begin n_bad++; $display("FAIL b2b_fv: iter %0d got %b want 1", i, b_fv); end
            n_cmp++; if (b_cnt !== 16'(3 + i)) begin n_bad++; $display("FAIL b2b_cnt: iter %0d got %h want %h", i, b_cnt, 16'(3 + i)); end
        end
        idle();
        tick();
        n_cmp++; if (b_fv !== 1'b0) begin n_bad++; $display("FAIL b2b_fv_drop: got %b want 0", b_fv); end
    endtask

    task automatic test_reset_midframe();
        logic [527:0] e;
        for (int k = 0; k < 32; k++) begin
            b_wv = 1'b1; b_wa = 6'(k); b_wd = 11'h055;
            tick();
        end
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (b_sig !== 528'd0) begin n_bad++; $display("FAIL midrst_async_sig: got %h want 0", b_sig); end
        n_cmp++; if (b_fm !== 48'd0)   begin n_bad++; $display("FAIL midrst_async_fm: got %h want 0", b_fm); end
        n_cmp++; if (b_cnt !== 16'd0)  begin n_bad++; $display("FAIL midrst_async_cnt: got %h want 0", b_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_wv = 1'b1; b_wa = 6'd1; b_wd = 11'd9;
        tick();
        idle();
        b_fe = 1'b1;
        tick();
        idle();
        e = '0;
        e[1*11 +: 11] = 11'd9;
        n_cmp++; if (b_sig !== e)     begin n_bad++; $display("FAIL midrst_sig: got %h want %h", b_sig, e); end
        n_cmp++; if (b_cnt !== 16'd1) begin n_bad++; $display("FAIL midrst_cnt: got %h want 1", b_cnt); end
        n_cmp++; if (b_fv !== 1'b1)   begin n_bad++; $display("FAIL midrst_fv: got %b want 1", b_fv); end
    endtask

    task automatic test_random();
        logic [703:0] ea;
        logic [527:0] eb;
        for (int i = 0; i < 600; i++) begin
            a_wv = ($urandom_range(0, 3) != 0);
            a_wa = 6'($urandom);
            a_wd = 11'($urandom);
            a_fe = ($urandom_range(0, 63) == 0);
            b_wv = ($urandom_range(0, 2) != 0);
            b_wa = 6'($urandom);
            b_wd = 11'($urandom);
            b_fe = ($urandom_range(0, 11) == 0);
            tick();
            ea = exp_a_sig();
            eb = exp_b_sig();
            n_cmp++; if (a_sig !== ea)        begin n_bad++; $display("FAIL rnd_a_sig: cyc %0d got %h want %h", i, a_sig, ea); end
            n_cmp++; if (a_fv !== m_fv[0])    begin n_bad++; $display("FAIL rnd_a_fv: cyc %0d got %b want %b", i, a_fv, m_fv[0]); end
            n_cmp++; if (a_fm !== m_fill[0])  begin n_bad++; $display("FAIL rnd_a_fm: cyc %0d got %h want %h", i, a_fm, m_fill[0]); end
            n_cmp++; if (a_err !== m_err[0])  begin n_bad++; $display("FAIL rnd_a_err: cyc %0d got %b want %b", i, a_err, m_err[0]); end
            n_cmp++; if (a_cnt !== m_cnt[0])  begin n_bad++; $display("FAIL rnd_a_cnt: cyc %0d got %h want %h", i, a_cnt, m_cnt[0]); end
            n_cmp++; if (b_sig !== eb)        begin n_bad++; $display("FAIL rnd_b_sig: cyc %0d got %h want %h", i, b_sig, eb); end
            n_cmp++; if (b_fv !== m_fv[1])    begin n_bad++; $display("FAIL rnd_b_fv: cyc %0d got %b want %b", i, b_fv, m_fv[1]); end
            n_cmp++; if (b_fm !== m_fill[1][47:0]) begin n_bad++; $display("FAIL rnd_b_fm: cyc %0d got %h want %h", i, b_fm, m_fill[1][47:0]); end
            n_cmp++; if (b_err !== m_err[1])  begin n_bad++; $display("FAIL rnd_b_err: cyc %0d got %b want %b", i, b_err, m_err[1]); end
            n_cmp++; if (b_cnt !== m_cnt[1])  begin n_bad++; $display("FAIL rnd_b_cnt: cyc %0d got %h want %h", i, b_cnt, m_cnt[1]); end
        end
        idle();
    endtask

    task automatic test_wrap();
        int fv_miss;
        do_reset();
        fv_miss = 0;
        b_fe = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            tick();
            if (b_fv !== 1'b1) fv_miss++;
        end
        n_cmp++; if (fv_miss != 0) begin n_bad++; $display("FAIL wrap_fv_each: got %0d missing pulses want 0", fv_miss); end
        n_cmp++; if (b_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_cnt_max: got %h want ffff", b_cnt); end
        tick();
        idle();
        n_cmp++; if (b_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_cnt_zero: got %h want 0", b_cnt); end
        n_cmp++; if (b_fv !== 1'b1)      begin n_bad++; $display("FAIL wrap_fv: got %b want 1", b_fv); end
        tick();
        n_cmp++; if (b_fv !== 1'b0)      begin n_bad++; $display("FAIL wrap_fv_drop: got %b want 0", b_fv); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        test_reset();
        test_auto_fill();
        test_rewrite();
        test_addr_err();
        test_same_cycle();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
